// File: rtl/alu_disp_pkg.sv
// Shared types and seven-segment constants for the ALU result display.
package alu_disp_pkg;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  typedef logic [3:0] disp_code_t;

  localparam disp_code_t CODE_MINUS = 4'd10;
  localparam disp_code_t CODE_BLANK = 4'd15;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [0:9][6:0] SEG_DIGIT = {
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/alu_result_display_seg7_decode.sv
// Combinational display-code to active-low seven-segment decoder.
module seg7_decode
  import alu_disp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (code <= 4'd9) begin
      seg = SEG_DIGIT[code];
    end else if (code == CODE_MINUS) begin
      seg = SEG_MINUS;
    end
  end

endmodule

// File: rtl/alu_result_display.sv
// ALU result to Basys3 4-digit seven-segment display: double-dabble conversion plus scan.
// Optional ALU_DISP_ZERO_BLANK_EN blanks a zero tens digit and moves the sign into it.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int CNT_W    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] res_in,
  input  logic       ovf_in,
  input  logic       cout_in,
  input  logic [2:0] mode_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  state_t           state_reg, state_next;
  logic [10:0]      snap_reg;
  logic             valid_reg;
  logic [2:0]       bit_cnt_reg;
  logic [6:0]       mag_reg;
  logic [3:0]       tens_reg, units_reg;
  logic             neg_reg;
  logic [3:0][3:0]  disp_reg;
  logic [1:0]       dp_flag_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       idx_reg;
  logic [6:0]       seg_reg;
  logic             dp_reg;
  logic [3:0]       an_reg;

  logic [10:0] snap_now;
  logic        start;
  logic        neg_now;
  logic [6:0]  mag_now;
  logic [3:0]  tens_adj, units_adj;
  logic [6:0]  seg_dig [4];

  assign snap_now = {mode_in, ovf_in, cout_in, res_in};
  assign start    = (state_reg == IDLE) && (!valid_reg || (snap_now != snap_reg));
  assign neg_now  = mode_in[1] && res_in[5];
  assign mag_now  = neg_now ? 7'(~{1'b1, res_in} + 7'd1) : {1'b0, res_in};

  // Double-dabble correction applied before each shift
  assign units_adj = (units_reg >= 4'd5) ? units_reg + 4'd3 : units_reg;
  assign tens_adj  = (tens_reg  >= 4'd5) ? tens_reg  + 4'd3 : tens_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (bit_cnt_reg == 3'd6) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_reg    <= '0;
      valid_reg   <= 1'b0;
      bit_cnt_reg <= '0;
      mag_reg     <= '0;
      tens_reg    <= '0;
      units_reg   <= '0;
      neg_reg     <= 1'b0;
      disp_reg    <= {4{CODE_BLANK}};
      dp_flag_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            snap_reg    <= snap_now;
            valid_reg   <= 1'b1;
            bit_cnt_reg <= '0;
            mag_reg     <= mag_now;
            neg_reg     <= neg_now;
            tens_reg    <= '0;
            units_reg   <= '0;
          end
        end
        CONV: begin
          {tens_reg, units_reg, mag_reg} <= {tens_adj[2:0], units_adj, mag_reg, 1'b0};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
        COMMIT: begin
          disp_reg[3] <= {1'b0, snap_reg[10:8]};
          disp_reg[0] <= units_reg;
          dp_flag_reg <= snap_reg[7:6];
`ifdef ALU_DISP_ZERO_BLANK_EN
          if (tens_reg == 4'd0) begin
            disp_reg[2] <= CODE_BLANK;
            disp_reg[1] <= neg_reg ? CODE_MINUS : CODE_BLANK;
          end else begin
            disp_reg[2] <= neg_reg ? CODE_MINUS : CODE_BLANK;
            disp_reg[1] <= tens_reg;
          end
`else
          disp_reg[2] <= neg_reg ? CODE_MINUS : CODE_BLANK;
          disp_reg[1] <= tens_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      seg7_decode u_dec (
        .code (disp_reg[gi]),
        .seg  (seg_dig[gi])
      );
    end
  endgenerate

  // Free-running scan; outputs lag the digit index by one register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
      an_reg  <= 4'hF;
    end else begin
      if (cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      seg_reg <= seg_dig[idx_reg];
      an_reg  <= ~(4'b0001 << idx_reg);
      dp_reg  <= ~(((idx_reg == 2'd0) && dp_flag_reg[0]) ||
                   ((idx_reg == 2'd1) && dp_flag_reg[1]));
    end
  end

  assign seg  = seg_reg;
  assign dp   = dp_reg;
  assign an   = an_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench: per-cycle compare against a behavioural display model plus literal frames.
module tb_alu_result_display;

  localparam int SD = 4;

  logic       clk;
  logic       rst;
  logic [5:0] res_in;
  logic       ovf_in;
  logic       cout_in;
  logic [2:0] mode_in;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_display #(.SCAN_DIV(SD), .CNT_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .res_in  (res_in),
    .ovf_in  (ovf_in),
    .cout_in (cout_in),
    .mode_in (mode_in),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Behavioural model: what each digit should show and when it changes
  bit          started = 0;
  int          k, rem;
  bit          m_valid;
  logic [10:0] m_snap;
  logic [6:0]  m_seg [4];
  logic        m_dp  [4];
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_dp;
  logic        exp_busy;

  task automatic model_load();
    int mode, r, mag, tens, units;
    bit neg;
    mode  = int'(m_snap[10:8]);
    r     = int'(m_snap[5:0]);
    neg   = m_snap[9] && m_snap[5];
    mag   = neg ? 64 - r : r;
    tens  = mag / 10;
    units = mag % 10;
    m_seg[3] = digit_seg(mode);
    m_seg[0] = digit_seg(units);
    m_seg[1] = digit_seg(tens);
    m_seg[2] = neg ? 7'b0111111 : 7'h7F;
`ifdef ALU_DISP_ZERO_BLANK_EN
    if (tens == 0) begin
      m_seg[1] = neg ? 7'b0111111 : 7'h7F;
      m_seg[2] = 7'h7F;
    end
`endif
    m_dp[0] = ~m_snap[6];
    m_dp[1] = ~m_snap[7];
    m_dp[2] = 1'b1;
    m_dp[3] = 1'b1;
  endtask

  always @(posedge clk) begin
    int idx;
    logic [10:0] cur;
    started = 1;
    cur = {mode_in, ovf_in, cout_in, res_in};
    if (rst) begin
      k = 0; rem = 0; m_valid = 0;
      for (int j = 0; j < 4; j++) begin
        m_seg[j] = 7'h7F;
        m_dp[j]  = 1'b1;
      end
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_busy = 1'b0;
    end else begin
      k++;
      idx     = ((k - 1) / SD) % 4;
      exp_an  = 4'(~(4'b0001 << idx));
      exp_seg = m_seg[idx];
      exp_dp  = m_dp[idx];
      if (rem > 0) begin
        rem--;
        if (rem == 0) model_load();
      end else if (!m_valid || cur != m_snap) begin
        m_snap  = cur;
        m_valid = 1;
        rem     = 8;
      end
      exp_busy = (rem > 0);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("an",   32'(an),   32'(exp_an));
      check("seg",  32'(seg),  32'(exp_seg));
      check("dp",   32'(dp),   32'(exp_dp));
    end
  end

  task automatic set_in(input logic [2:0] m, input logic [5:0] r, input logic o, input logic c);
    mode_in = m; res_in = r; ovf_in = o; cout_in = c;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  // Capture one full refresh and compare to hand-computed segments; edp is per-digit dp (active low)
  task automatic check_frame(input string nm, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0, input logic [3:0] edp);
    logic [6:0] cs [4];
    logic       cd [4];
    for (int j = 0; j < 4; j++) begin
      cs[j] = 7'h55;
      cd[j] = 1'bx;
    end
    for (int i = 0; i < 4 * SD; i++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (an === 4'(~(4'b0001 << j))) begin
          cs[j] = seg;
          cd[j] = dp;
        end
      end
    end
    check({nm, "_d3"}, 32'(cs[3]), 32'(e3));
    check({nm, "_d2"}, 32'(cs[2]), 32'(e2));
    check({nm, "_d1"}, 32'(cs[1]), 32'(e1));
    check({nm, "_d0"}, 32'(cs[0]), 32'(e0));
    check({nm, "_dp"}, 32'({cd[3], cd[2], cd[1], cd[0]}), 32'(edp));
    $display("txn %s: seg d3..d0 = %h %h %h %h dp=%b%b%b%b", nm, cs[3], cs[2], cs[1], cs[0],
             cd[3], cd[2], cd[1], cd[0]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, saw9, rises;
    logic prev_busy;

    rst = 1'b1;
    set_in(3'b000, 6'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_seg",  32'(seg),  32'h7F);
    check("rst_an",   32'(an),   32'hF);
    check("rst_dp",   32'(dp),   32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    $display("txn reset: seg=%h an=%b dp=%b busy=%b", seg, an, dp, busy);

    // 110, 27: busy for exactly 8 edges, then "6", blank, "2", "7"
    set_in(3'b110, 6'd27, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("first_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", 32'(n), 32'd8);
    check_frame("m6_27", 7'h02, 7'h7F, 7'h24, 7'h78, 4'b1111);

    set_in(3'b111, 6'b100000, 1'b1, 1'b1);
    wait_idle("m7_neg32");
    check_frame("m7_neg32", 7'h78, 7'b0111111, 7'h30, 7'h24, 4'b1100);

    set_in(3'b101, 6'd63, 1'b0, 1'b0);
    wait_idle("m5_63");
    check_frame("m5_63", 7'h12, 7'h7F, 7'h02, 7'h30, 4'b1111);

    // Inputs changing mid-conversion: 9 must never appear, exactly two conversions
    set_in(3'b000, 6'd5, 1'b0, 1'b0);
    saw9 = 0; rises = 0; prev_busy = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 3) res_in = 6'd9;
      if (i == 5) res_in = 6'd12;
      if (busy === 1'b1 && prev_busy === 1'b0) rises++;
      prev_busy = busy;
      if (an === 4'b1110 && seg === 7'h10) saw9++;
    end
    check("no_nine", 32'(saw9), 32'd0);
    check("two_convs", 32'(rises), 32'd2);
    check_frame("m0_12", 7'h40, 7'h7F, 7'h79, 7'h24, 4'b1111);

    // Reset during the third CONV cycle, then convert the held inputs afresh
    set_in(3'b011, 6'b111011, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_seg",  32'(seg),  32'h7F);
    check("mid_rst_an",   32'(an),   32'hF);
    check("mid_rst_dp",   32'(dp),   32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd1);
    wait_idle("m3_neg5");
`ifdef ALU_DISP_ZERO_BLANK_EN
    check_frame("m3_neg5", 7'h30, 7'h7F, 7'b0111111, 7'h12, 4'b1101);
`else
    check_frame("m3_neg5", 7'h30, 7'b0111111, 7'h40, 7'h12, 4'b1101);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
